// File: rtl/pipeline_result_collector_pkg.sv
// Shared definitions for the pipeline result collector and its result FIFO.
// Holds the pipeline geometry, the FIFO operation encoding and a width helper.
package pipeline_result_collector_pkg;

   // Data width of the arithmetic pipeline F = ((A+B)+(C-D))*D.
   localparam int PIPE_N    = 10;
   // Clocks from operands presented at issue to F valid on the pipeline output.
   localparam int PIPE_LAT  = 3;
   // Default number of buffered results.
   localparam int PRC_DEPTH = 4;

   // Combined push/pop request seen by the result FIFO in one cycle.
   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_POP  = 2'b01,
      FIFO_PUSH = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   // Ceiling log2 for elaboration-time widths; clog2(1) and clog2(0) are 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pipeline_result_collector_sync_fifo.sv
// Small synchronous first-word fall-through FIFO for pipeline results.
// The head entry is always visible on rd_data; occupancy is tracked in a
// separate level counter so the pointers can simply wrap.
module pipe_sync_fifo
   import pipeline_result_collector_pkg::*;
#(
   parameter int N     = PIPE_N,
   parameter int DEPTH = PRC_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [N-1:0]           wr_data,
   input  logic                   rd_en,
   output logic [N-1:0]           rd_data,
   output logic [clog2(DEPTH):0]  level
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;
   fifo_op_e      fifo_op;

   // A pop on an empty FIFO is ignored; a push into a full FIFO is only
   // allowed when the head leaves in the same cycle, so no entry is lost.
   always_comb begin
      do_pop  = rd_en && (level != '0);
      do_push = wr_en && ((level != FULL_LEVEL) || do_pop);
      fifo_op = fifo_op_e'({do_push, do_pop});
   end

   // The head entry is presented directly from storage (fall-through).
   assign rd_data = mem[rd_ptr];

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case (fifo_op)
            FIFO_PUSH: level <= level + LW'(1);
            FIFO_POP:  level <= level - LW'(1);
            default:   level <= level;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_result_collector.sv
// Downstream companion to the fixed-latency arithmetic pipeline.
// The pipeline itself has no valid or stall, so this block follows each
// accepted operand set with a token, captures F when the token reaches the
// end of the line, and buffers results behind a valid/ready port. Issue
// credits count both buffered and in-flight results so the FIFO never overflows.
module pipeline_result_collector
   import pipeline_result_collector_pkg::*;
#(
   parameter int N     = PIPE_N,
   parameter int LAT   = PIPE_LAT,
   parameter int DEPTH = PRC_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid,
   output logic                   issue_ready,
   input  logic [N-1:0]           f_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           out_data,
   output logic [clog2(DEPTH):0]  level
);

   localparam int LW = clog2(DEPTH) + 1;
   localparam int CW = clog2(DEPTH + LAT + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [LAT-1:0] token_line;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  credit_sum;
   logic           accept;
   logic           capture;
   logic           pop;

   // Credits come only from registered state; a pop in this cycle frees its
   // slot for issue in the next cycle, never combinationally.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + CW'(token_line[i]);
      end
      credit_sum  = CW'(level) + inflight;
      issue_ready = (credit_sum < CW'(DEPTH));
   end

   assign accept    = issue_valid && issue_ready;
   assign capture   = token_line[LAT-1];
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready;

   // Token line mirrors the pipeline depth; the last bit marks a cycle whose F is real.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         token_line <= '0;
      end else begin
         token_line[0] <= accept;
         for (int i = 1; i < LAT; i++) begin
            token_line[i] <= token_line[i-1];
         end
      end
   end

   pipe_sync_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (capture),
      .wr_data (f_in),
      .rd_en   (pop),
      .rd_data (out_data),
      .level   (level)
   );

   // A capture into a full FIFO without a simultaneous pop means credits were miscounted.
   PRC_OVF: assert property (@(posedge clk) disable iff (rst)
      !(capture && (level == FULL_LEVEL) && !pop));

endmodule
